// File: rtl/hamming_stream_ctrl.sv
// rtl/hamming_stream_ctrl.sv - burst sequencer around a fixed-latency 12/8 Hamming coder
//
// Purpose: accepts a LEN-byte burst over a valid/ready handshake, feeds the
// bytes one per cycle into the coder, re-times the coder output into a
// valid-tagged stream with a last marker, and counts decoder corrections.
//
// Ports:
//   clk, arstn                 clock, asynchronous active-low reset
//   start, len                 burst request (sampled in IDLE) and burst length
//   s_data, s_valid, s_ready   upstream byte stream
//   enc_data                   registered byte into the coder
//   enc_q, dec_err             coder output and its correction flag
//   m_data, m_valid, m_last    downstream byte stream (no back-pressure)
//   busy, done                 burst in progress / one-cycle completion pulse
//   clr_cnt, err_cnt           synchronous clear / saturating correction count
module hamming_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int LAT    = 2,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] enc_data,
  input  logic [DATA_W-1:0] enc_q,
  input  logic              dec_err,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] in_rem, out_rem;
  logic             accept;

  // tag[0] marks a valid byte sitting in enc_data; the coder then adds LAT
  // cycles, so tag[LAT] lines up with the matching byte on enc_q.
  logic [LAT:0]     tag;

  assign s_ready = (state == RUN);
  assign accept  = s_valid & s_ready;
  assign m_data  = enc_q;
  assign m_valid = tag[LAT];
  assign m_last  = m_valid && (out_rem == LEN_W'(1));
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (in_rem == LEN_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave only once every in-flight byte has been emitted.
        if ((tag == '0) && (out_rem == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      in_rem   <= '0;
      out_rem  <= '0;
      tag      <= '0;
      enc_data <= '0;
    end else begin
      state <= state_nxt;
      tag   <= {tag[LAT-1:0], accept};

      if (accept) begin
        enc_data <= s_data;
      end

      if ((state == IDLE) && start) begin
        in_rem <= len;
      end else if (accept) begin
        in_rem <= in_rem - LEN_W'(1);
      end

      if ((state == IDLE) && start) begin
        out_rem <= len;
      end else if (m_valid) begin
        out_rem <= out_rem - LEN_W'(1);
      end
    end
  end

  // Correction counter persists across bursts; clear has priority.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (m_valid && dec_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
